usb_rx_depacketizer: RTL and testbench

USB_RX_DEPACKETIZER -- requirements
Module: usb_rx_depacketizer

---
 rtl/usb_rx_depacketizer.sv | 244 ++++++++++++++++++++++++
 tb/tb_usb_rx_depacketizer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_depacketizer.sv
// Low Speed USB receive depacketizer: NRZI decode, bit unstuffing, SYNC/PID/EOP
// framing. Everything advances on bit_strobe; the output pulses last one cycle.
package types;
  typedef enum logic [1:0] {
    SE0 = 2'b00,
    J   = 2'b01,
    K   = 2'b10,
    SE1 = 2'b11
  } d_port_t;

  typedef logic [3:0] pid_t;

  localparam pid_t PID_OUT   = 4'b0001;
  localparam pid_t PID_IN    = 4'b1001;
  localparam pid_t PID_SOF   = 4'b0101;
  localparam pid_t PID_SETUP = 4'b1101;
  localparam pid_t PID_DATA0 = 4'b0011;
  localparam pid_t PID_DATA1 = 4'b1011;
  localparam pid_t PID_ACK   = 4'b0010;
  localparam pid_t PID_NAK   = 4'b1010;
  localparam pid_t PID_STALL = 4'b1110;
  localparam pid_t PID_PRE   = 4'b1100;

  function automatic logic pid_known(input pid_t p);
    case (p)
      PID_OUT, PID_IN, PID_SOF, PID_SETUP, PID_DATA0,
      PID_DATA1, PID_ACK, PID_NAK, PID_STALL, PID_PRE: pid_known = 1'b1;
      default: pid_known = 1'b0;
    endcase
  endfunction
endpackage

// Handshake: no backpressure. rx_data is meaningful only in the cycle rx_valid
// is high; rx_sop marks the PID byte; rx_eop/rx_error close a packet, never both.
module usb_rx_depacketizer (
  input  logic            clk,
  input  logic            reset_n,
  input  types::d_port_t  line,
  input  logic            bit_strobe,
  output logic            rx_active,
  output logic [7:0]      rx_data,
  output logic            rx_valid,
  output logic            rx_sop,
  output types::pid_t     rx_pid,
  output logic            rx_eop,
  output logic            rx_error,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    DATA   = 3'd2,
    EOP    = 3'd3,
    WAIT_J = 3'd4
  } state_t;

  state_t         state, state_nx;
  types::d_port_t prev_sym, prev_nx;
  logic [1:0]     zero_cnt, zero_nx;
  logic [2:0]     ones_cnt, ones_nx;
  logic [2:0]     bit_cnt, bit_nx;
  logic [7:0]     shreg, shreg_nx;
  logic           first_byte, first_nx;
  logic           aligned, aligned_nx;
  logic [1:0]     se0_cnt, se0_nx;
  logic [7:0]     data_nx;
  types::pid_t    pid_nx;
  logic           valid_nx, sop_nx, eop_nx, err_nx;
  logic           dbit;
  logic [7:0]     byte_full;

  assign dbit      = (line == prev_sym);
  assign byte_full = {dbit, shreg[7:1]};
  assign rx_active = (state == DATA) || (state == EOP);
  assign dbg_state = state;

  always_comb begin
    state_nx   = state;
    prev_nx    = prev_sym;
    zero_nx    = zero_cnt;
    ones_nx    = ones_cnt;
    bit_nx     = bit_cnt;
    shreg_nx   = shreg;
    first_nx   = first_byte;
    aligned_nx = aligned;
    se0_nx     = se0_cnt;
    data_nx    = rx_data;
    pid_nx     = rx_pid;
    valid_nx   = 1'b0;
    sop_nx     = 1'b0;
    eop_nx     = 1'b0;
    err_nx     = 1'b0;

    if (bit_strobe) begin
      // Line-state symbols (SE0/SE1) never disturb the NRZI reference.
      if (line == types::J || line == types::K) prev_nx = line;

      case (state)
        IDLE: begin
          if (line == types::K) begin
            state_nx = SYNC;
            zero_nx  = 2'd1;
          end
        end

        SYNC: begin
          case (line)
            types::SE0: state_nx = IDLE;
            types::SE1: begin
              err_nx   = 1'b1;
              state_nx = WAIT_J;
            end
            default: begin
              if (!dbit) begin
                zero_nx = (zero_cnt == 2'd3) ? 2'd3 : zero_cnt + 2'd1;
              end else if (zero_cnt == 2'd3) begin
                state_nx   = DATA;
                ones_nx    = 3'd0;
                bit_nx     = 3'd0;
                shreg_nx   = 8'h00;
                first_nx   = 1'b1;
                aligned_nx = 1'b1;
              end else begin
                state_nx = IDLE;
              end
            end
          endcase
        end

        DATA: begin
          case (line)
            types::SE0: begin
              state_nx = EOP;
              se0_nx   = 2'd1;
              if (bit_cnt != 3'd0) begin
                err_nx     = 1'b1;
                aligned_nx = 1'b0;
              end
            end
            types::SE1: begin
              err_nx   = 1'b1;
              state_nx = WAIT_J;
            end
            default: begin
              if (ones_cnt == 3'd6) begin
                // Stuffed zero is dropped; a seventh one is a stuff violation.
                if (!dbit) begin
                  ones_nx = 3'd0;
                end else begin
                  err_nx   = 1'b1;
                  state_nx = WAIT_J;
                end
              end else begin
                ones_nx  = dbit ? ones_cnt + 3'd1 : 3'd0;
                shreg_nx = byte_full;
                bit_nx   = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  data_nx  = byte_full;
                  valid_nx = 1'b1;
                  if (first_byte) begin
                    first_nx = 1'b0;
                    sop_nx   = 1'b1;
                    pid_nx   = byte_full[3:0];
                    if ((byte_full[7:4] != ~byte_full[3:0]) ||
                        !types::pid_known(byte_full[3:0])) begin
                      err_nx   = 1'b1;
                      state_nx = WAIT_J;
                    end
                  end
                end
              end
            end
          endcase
        end

        EOP: begin
          // A misaligned packet already reported its error on entry.
          case (line)
            types::SE0: begin
              if (se0_cnt == 2'd2) begin
                err_nx   = aligned;
                state_nx = WAIT_J;
              end else begin
                se0_nx = 2'd2;
              end
            end
            types::J: begin
              eop_nx   = aligned;
              state_nx = IDLE;
            end
            default: begin
              err_nx   = aligned;
              state_nx = WAIT_J;
            end
          endcase
        end

        WAIT_J: begin
          if (line == types::J) state_nx = IDLE;
        end

        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      prev_sym   <= types::J;
      zero_cnt   <= 2'd0;
      ones_cnt   <= 3'd0;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      first_byte <= 1'b0;
      aligned    <= 1'b0;
      se0_cnt    <= 2'd0;
      rx_data    <= 8'h00;
      rx_pid     <= 4'b0000;
      rx_valid   <= 1'b0;
      rx_sop     <= 1'b0;
      rx_eop     <= 1'b0;
      rx_error   <= 1'b0;
    end else begin
      state      <= state_nx;
      prev_sym   <= prev_nx;
      zero_cnt   <= zero_nx;
      ones_cnt   <= ones_nx;
      bit_cnt    <= bit_nx;
      shreg      <= shreg_nx;
      first_byte <= first_nx;
      aligned    <= aligned_nx;
      se0_cnt    <= se0_nx;
      rx_data    <= data_nx;
      rx_pid     <= pid_nx;
      rx_valid   <= valid_nx;
      rx_sop     <= sop_nx;
      rx_eop     <= eop_nx;
      rx_error   <= err_nx;
    end
  end

endmodule

// File: tb/tb_usb_rx_depacketizer.sv
// Bench for usb_rx_depacketizer: NRZI/stuffing encoder drives packets, a monitor
// records delivered bytes and pulses, and an expected queue is checked per packet.
module tb_usb_rx_depacketizer;
  import types::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  d_port_t     line = J;
  logic        bit_strobe = 1'b0;
  logic        rx_active;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_sop;
  pid_t        rx_pid;
  logic        rx_eop;
  logic        rx_error;
  logic [2:0]  dbg_state;

  usb_rx_depacketizer dut (
    .clk(clk), .reset_n(reset_n), .line(line), .bit_strobe(bit_strobe),
    .rx_active(rx_active), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_sop(rx_sop), .rx_pid(rx_pid), .rx_eop(rx_eop), .rx_error(rx_error),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Monitor: every delivered byte as {sop, data}, plus pulse counts.
  logic [8:0] got_q[$];
  int eop_cnt = 0;
  int err_cnt = 0;
  always @(negedge clk) begin
    if (rx_valid) got_q.push_back({rx_sop, rx_data});
    if (rx_eop) eop_cnt++;
    if (rx_error) err_cnt++;
  end

  logic [8:0] exp_q[$];
  int n_cmp = 0;
  int n_miss = 0;
  int rd_idx = 0;
  int ones = 0;
  d_port_t tb_prev = J;
  int e0, r0;
  logic [7:0] last_byte;

  typedef struct {
    string      name;
    logic [7:0] pid;
    int         nbytes;
    logic [7:0] d0;
    logic [7:0] d1;
    int         extra;
    logic       exp_eop;
    logic       exp_err;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic tb_pid_ok(input logic [7:0] b);
    logic [3:0] codes[10] = '{4'h1, 4'h9, 4'h5, 4'hD, 4'h3, 4'hB, 4'h2, 4'hA, 4'hE, 4'hC};
    logic hit = 1'b0;
    for (int i = 0; i < 10; i++) if (b[3:0] == codes[i]) hit = 1'b1;
    return hit && (b[7:4] == ~b[3:0]);
  endfunction

  task automatic send_sym(input d_port_t s);
    @(posedge clk); #1;
    line = s;
    bit_strobe = 1'b1;
    @(posedge clk); #1;
    bit_strobe = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_raw_bit(input logic b);
    d_port_t s;
    s = b ? tb_prev : ((tb_prev == J) ? K : J);
    send_sym(s);
    tb_prev = s;
  endtask

  task automatic send_dbit(input logic b);
    send_raw_bit(b);
    ones = b ? ones + 1 : 0;
    if (ones == 6) begin
      send_raw_bit(1'b0);
      ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_dbit(v[i]);
  endtask

  task automatic send_sync();
    d_port_t pat[8] = '{K, J, K, J, K, J, K, K};
    for (int i = 0; i < 8; i++) send_sym(pat[i]);
    tb_prev = K;
    ones = 0;
  endtask

  task automatic send_eop();
    send_sym(SE0);
    send_sym(SE0);
    send_sym(J);
    tb_prev = J;
  endtask

  task automatic begin_pkt(input string tag, input logic [7:0] pid);
    e0 = eop_cnt;
    r0 = err_cnt;
    send_sync();
    chk({tag, "_active_after_sync"}, rx_active, 1);
    send_byte(pid);
    exp_q.push_back({1'b1, pid});
    last_byte = pid;
  endtask

  task automatic check_bytes(input string tag);
    logic [8:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_idx < got_q.size()) begin
        chk({tag, "_byte"}, got_q[rd_idx], e);
        rd_idx++;
      end else begin
        n_cmp++;
        n_miss++;
        $display("FAIL %s_missing got=none exp=%0h", tag, e);
      end
    end
    chk({tag, "_extra_bytes"}, got_q.size(), rd_idx);
    rd_idx = got_q.size();
  endtask

  task automatic check_end(input string tag, input int eops, input int errs);
    repeat (3) @(posedge clk);
    #1;
    check_bytes(tag);
    chk({tag, "_eop_count"}, eop_cnt - e0, eops);
    chk({tag, "_err_count"}, err_cnt - r0, errs);
    chk({tag, "_active_low"}, rx_active, 0);
  endtask

  task automatic run_vec(input vec_t v);
    logic ok;
    begin_pkt(v.name, v.pid);
    ok = tb_pid_ok(v.pid);
    if (v.nbytes > 0) begin
      send_byte(v.d0);
      if (ok) begin exp_q.push_back({1'b0, v.d0}); last_byte = v.d0; end
    end
    if (v.nbytes > 1) begin
      send_byte(v.d1);
      if (ok) begin exp_q.push_back({1'b0, v.d1}); last_byte = v.d1; end
    end
    for (int i = 0; i < v.extra; i++) send_dbit(1'(i % 2 == 0));
    send_eop();
    check_end(v.name, v.exp_eop ? 1 : 0, v.exp_err ? 1 : 0);
    chk({v.name, "_pid"}, rx_pid, v.pid[3:0]);
    chk({v.name, "_data_hold"}, rx_data, last_byte);
    chk({v.name, "_idle"}, dbg_state, 3'd0);
  endtask

  initial begin
    vecs[0] = '{"ack",       8'hD2, 0, 8'h00, 8'h00, 0, 1'b1, 1'b0};
    vecs[1] = '{"data0",     8'hC3, 2, 8'hFF, 8'h01, 0, 1'b1, 1'b0};
    vecs[2] = '{"bad_cpl",   8'hD3, 1, 8'hFF, 8'h00, 0, 1'b0, 1'b1};
    vecs[3] = '{"misalign",  8'hD2, 0, 8'h00, 8'h00, 5, 1'b0, 1'b1};
    vecs[4] = '{"data1_rnd", 8'h4B, 2, 8'h00, 8'h00, 0, 1'b1, 1'b0};
    vecs[5] = '{"bad_code",  8'hF0, 0, 8'h00, 8'h00, 0, 1'b0, 1'b1};
    vecs[4].d0 = 8'($urandom_range(0, 255));
    vecs[4].d1 = 8'($urandom_range(0, 255));

    repeat (3) @(posedge clk);
    #1;
    chk("rst_active", rx_active, 0);
    chk("rst_outputs", {rx_valid, rx_sop, rx_eop, rx_error}, 4'b0000);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_pid", rx_pid, 4'b0000);
    chk("rst_state", dbg_state, 3'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // SE1 while receiving aborts the packet.
    begin_pkt("se1", 8'hD2);
    send_sym(SE1);
    chk("se1_active", rx_active, 0);
    send_sym(J);
    tb_prev = J;
    check_end("se1", 0, 1);
    chk("se1_idle", dbg_state, 3'd0);

    // Seven unchanged symbols: a stuff violation.
    begin_pkt("stuff", 8'hD2);
    for (int i = 0; i < 7; i++) send_sym(tb_prev);
    chk("stuff_state", dbg_state, 3'd4 * 3'(tb_prev == K) | 3'd0);
    send_sym(J);
    tb_prev = J;
    check_end("stuff", 0, 1);
    chk("stuff_idle", dbg_state, 3'd0);

    // Three SE0s is not a legal EOP.
    begin_pkt("se0x3", 8'hD2);
    send_sym(SE0);
    send_sym(SE0);
    send_sym(SE0);
    chk("se0x3_wait", dbg_state, 3'd4);
    send_sym(J);
    tb_prev = J;
    check_end("se0x3", 0, 1);

    // Short SYNC and SE1 in IDLE are both silent.
    e0 = eop_cnt;
    r0 = err_cnt;
    send_sym(K);
    send_sym(J);
    send_sym(J);
    chk("short_sync_idle", dbg_state, 3'd0);
    send_sym(SE1);
    send_sym(J);
    tb_prev = J;
    check_end("quiet", 0, 0);
    chk("quiet_idle", dbg_state, 3'd0);

    // Reset in the middle of a packet, then a clean ACK.
    begin_pkt("midrst", 8'hD2);
    send_dbit(1'b1);
    send_dbit(1'b0);
    send_dbit(1'b1);
    send_dbit(1'b1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    line = J;
    @(posedge clk); #1;
    chk("midrst_active", rx_active, 0);
    chk("midrst_pulses", {rx_valid, rx_sop, rx_eop, rx_error}, 4'b0000);
    chk("midrst_data", rx_data, 8'h00);
    chk("midrst_pid", rx_pid, 4'b0000);
    reset_n = 1'b1;
    tb_prev = J;
    check_end("midrst", 0, 0);
    chk("midrst_idle", dbg_state, 3'd0);
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule
